// File: rtl/led_scan_capture.sv
// rtl/led_scan_capture.sv - rebuilds 8x8 red/green frames from row-scan outputs and checks scan order.
// Optional frame_changed compare is built only when LED_SCAN_CAPTURE_CHANGE_EN is defined.
module led_scan_capture #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [7:0]  row,
  input  logic [7:0]  r_col,
  input  logic [7:0]  g_col,
  output logic [63:0] frame_r,
  output logic [63:0] frame_g,
  output logic        frame_valid,
  output logic [6:0]  red_count,
  output logic [6:0]  green_count,
  output logic        conflict,
  output logic        seq_err,
  output logic        bad_row,
  output logic        stall,
  output logic        frame_changed
);

  localparam logic SYNC    = 1'b0;
  localparam logic CAPTURE = 1'b1;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic        state;
  logic [2:0]  expected;
  logic [63:0] shadow_r;
  logic [63:0] shadow_g;
  logic [6:0]  acc_r;
  logic [6:0]  acc_g;
  logic        acc_c;
  logic        publish;
  logic [15:0] idle_cnt;

  logic        row_ok;
  logic [2:0]  row_idx;
  logic [3:0]  pc_r;
  logic [3:0]  pc_g;
  logic        pix_conflict;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  always_comb begin
    row_idx = 3'd0;
    row_ok  = (popcount8(~row) == 4'd1);
    for (int i = 0; i < 8; i++) begin
      if (!row[i]) row_idx = i[2:0];
    end
    pc_r         = popcount8(r_col);
    pc_g         = popcount8(g_col);
    pix_conflict = |(r_col & g_col);
  end

  assign stall = (idle_cnt == TIMEOUT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      expected    <= 3'd0;
      shadow_r    <= '0;
      shadow_g    <= '0;
      acc_r       <= '0;
      acc_g       <= '0;
      acc_c       <= 1'b0;
      publish     <= 1'b0;
      idle_cnt    <= '0;
      frame_r     <= '0;
      frame_g     <= '0;
      frame_valid <= 1'b0;
      red_count   <= '0;
      green_count <= '0;
      conflict    <= 1'b0;
      seq_err     <= 1'b0;
      bad_row     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      bad_row     <= 1'b0;
      publish     <= 1'b0;

      // Publish reads the pre-edge shadow, so a row 0 landing on this edge is safe.
      if (publish) begin
        frame_r     <= shadow_r;
        frame_g     <= shadow_g;
        red_count   <= acc_r;
        green_count <= acc_g;
        conflict    <= acc_c;
        frame_valid <= 1'b1;
      end

      if (sample_en) begin
        idle_cnt <= '0;
        if (!row_ok) begin
          bad_row  <= 1'b1;
          state    <= SYNC;
          expected <= 3'd0;
          acc_r    <= '0;
          acc_g    <= '0;
          acc_c    <= 1'b0;
        end else if (state == CAPTURE && row_idx == expected) begin
          shadow_r[{row_idx, 3'b000} +: 8] <= r_col;
          shadow_g[{row_idx, 3'b000} +: 8] <= g_col;
          if (expected == 3'd0) begin
            acc_r <= {3'b000, pc_r};
            acc_g <= {3'b000, pc_g};
            acc_c <= pix_conflict;
          end else begin
            acc_r <= acc_r + {3'b000, pc_r};
            acc_g <= acc_g + {3'b000, pc_g};
            acc_c <= acc_c | pix_conflict;
          end
          if (expected == 3'd7) publish <= 1'b1;
          expected <= expected + 3'd1;
        end else if (row_idx == 3'd0) begin
          // Fresh start of a frame, either from SYNC or as an out-of-order restart.
          seq_err  <= (state == CAPTURE);
          shadow_r[7:0] <= r_col;
          shadow_g[7:0] <= g_col;
          acc_r    <= {3'b000, pc_r};
          acc_g    <= {3'b000, pc_g};
          acc_c    <= pix_conflict;
          state    <= CAPTURE;
          expected <= 3'd1;
        end else if (state == CAPTURE) begin
          seq_err  <= 1'b1;
          state    <= SYNC;
          expected <= 3'd0;
        end
      end else if (idle_cnt != TIMEOUT_W) begin
        idle_cnt <= idle_cnt + 16'd1;
        if (idle_cnt + 16'd1 == TIMEOUT_W) begin
          state    <= SYNC;
          expected <= 3'd0;
        end
      end
    end
  end

`ifdef LED_SCAN_CAPTURE_CHANGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_changed <= 1'b0;
    end else begin
      frame_changed <= publish && ((shadow_r != frame_r) || (shadow_g != frame_g));
    end
  end
`else
  assign frame_changed = 1'b0;
`endif

endmodule

// File: tb/tb_led_scan_capture.sv
// tb/tb_led_scan_capture.sv - self-checking bench for led_scan_capture.
// Honours LED_SCAN_CAPTURE_CHANGE_EN when it is defined for the build.
module tb_led_scan_capture;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [7:0]  row;
  logic [7:0]  r_col;
  logic [7:0]  g_col;
  logic [63:0] frame_r;
  logic [63:0] frame_g;
  logic        frame_valid;
  logic [6:0]  red_count;
  logic [6:0]  green_count;
  logic        conflict;
  logic        seq_err;
  logic        bad_row;
  logic        stall;
  logic        frame_changed;

  int n_cmp = 0;
  int n_bad = 0;

  led_scan_capture #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .row(row), .r_col(r_col), .g_col(g_col),
    .frame_r(frame_r), .frame_g(frame_g), .frame_valid(frame_valid),
    .red_count(red_count), .green_count(green_count), .conflict(conflict),
    .seq_err(seq_err), .bad_row(bad_row), .stall(stall), .frame_changed(frame_changed)
  );

  always #5 clk = ~clk;

`ifdef LED_SCAN_CAPTURE_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  // Reference model: a frame is the run of rows 0,1,2.. collected in order.
  logic [15:0] run[$];
  bit          synced;
  int          idle;
  bit          pend;
  logic [63:0] pend_r, pend_g;
  logic [63:0] m_fr, m_fg;
  logic [6:0]  m_rc, m_gc;
  bit          m_conf, m_fv, m_se, m_br, m_chg;

  task automatic model_reset();
    run.delete();
    synced = 0; idle = 0; pend = 0; pend_r = '0; pend_g = '0;
    m_fr = '0; m_fg = '0; m_rc = '0; m_gc = '0;
    m_conf = 0; m_fv = 0; m_se = 0; m_br = 0; m_chg = 0;
  endtask

  task automatic model_edge(input logic en, input logic [7:0] rw, input logic [7:0] r, input logic [7:0] g);
    int k;
    m_fv = 0; m_se = 0; m_br = 0; m_chg = 0;
    if (pend) begin
      m_chg  = CHG_EN && ((pend_r != m_fr) || (pend_g != m_fg));
      m_fr   = pend_r;
      m_fg   = pend_g;
      m_rc   = 7'($countones(pend_r));
      m_gc   = 7'($countones(pend_g));
      m_conf = |(pend_r & pend_g);
      m_fv   = 1;
      pend   = 0;
    end
    if (en) begin
      idle = 0;
      if ($countones(~rw) != 1) begin
        m_br = 1; synced = 0; run.delete();
      end else begin
        k = 0;
        for (int i = 0; i < 8; i++) if (!rw[i]) k = i;
        if (!synced) begin
          if (k == 0) begin synced = 1; run.delete(); run.push_back({r, g}); end
        end else if (k == run.size()) begin
          run.push_back({r, g});
          if (run.size() == 8) begin
            pend_r = '0; pend_g = '0;
            for (int i = 0; i < 8; i++) begin
              pend_r = pend_r | (64'(run[i][15:8]) << (8 * i));
              pend_g = pend_g | (64'(run[i][7:0]) << (8 * i));
            end
            pend = 1;
            run.delete();
          end
        end else begin
          m_se = 1;
          run.delete();
          if (k == 0) run.push_back({r, g});
          else synced = 0;
        end
      end
    end else begin
      if (idle < T) idle++;
      if (idle == T) begin synced = 0; run.delete(); end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("frame_r", frame_r, m_fr);
    chk("frame_g", frame_g, m_fg);
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("red_count", 64'(red_count), 64'(m_rc));
    chk("green_count", 64'(green_count), 64'(m_gc));
    chk("conflict", 64'(conflict), 64'(m_conf));
    chk("seq_err", 64'(seq_err), 64'(m_se));
    chk("bad_row", 64'(bad_row), 64'(m_br));
    chk("stall", 64'(stall), 64'(idle == T));
    chk("frame_changed", 64'(frame_changed), 64'(m_chg));
  endtask

  task automatic step(input logic en, input logic [7:0] rw, input logic [7:0] r, input logic [7:0] g);
    @(negedge clk);
    sample_en = en; row = rw; r_col = r; g_col = g;
    @(posedge clk);
    model_edge(en, rw, r, g);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_en = 1'b0; row = 8'hFF; r_col = '0; g_col = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] oh(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  typedef struct {
    logic       en;
    logic [7:0] rw, r, g;
    logic       fv, se, br;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic en, input logic [7:0] rw, input logic [7:0] r, input logic [7:0] g,
                              input logic fv, input logic se, input logic br);
    vec_t v;
    v.en = en; v.rw = rw; v.r = r; v.g = g; v.fv = fv; v.se = se; v.br = br;
    tbl.push_back(v);
  endfunction

  task automatic run_table();
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].rw, tbl[i].r, tbl[i].g);
      chk($sformatf("tbl%0d.fv", i), 64'(frame_valid), 64'(tbl[i].fv));
      chk($sformatf("tbl%0d.se", i), 64'(seq_err), 64'(tbl[i].se));
      chk($sformatf("tbl%0d.br", i), 64'(bad_row), 64'(tbl[i].br));
    end
    tbl.delete();
  endtask

  logic [7:0] hg_r[8];
  logic [7:0] hg_g[8];

  initial begin
    rst = 1'b1; sample_en = 1'b0; row = 8'hFF; r_col = '0; g_col = '0;
    model_reset();
    do_reset();

    // Full red frame.
    for (int k = 0; k < 8; k++) add(1, oh(k), 8'hFF, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 0, 0, 1, 0, 0);
    run_table();
    chk("allred.frame_r", frame_r, {64{1'b1}});
    chk("allred.frame_g", frame_g, 64'd0);
    chk("allred.red_count", 64'(red_count), 64'd64);
    chk("allred.green_count", 64'(green_count), 64'd0);
    chk("allred.conflict", 64'(conflict), 64'd0);

    // Hourglass, sent twice back-to-back.
    hg_r = '{8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    hg_g = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h3C, 8'h7E, 8'hFF};
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) add(1, oh(k), hg_r[k], hg_g[k], (f == 1 && k == 0), 0, 0);
    add(0, 8'hFF, 0, 0, 1, 0, 0);
    run_table();
    chk("hg.frame_r", frame_r, 64'h00000000_183C7EFF);
    chk("hg.frame_g", frame_g, 64'hFF7E3C18_00000000);
    chk("hg.red_count", 64'(red_count), 64'd20);
    chk("hg.green_count", 64'(green_count), 64'd20);
    chk("hg.conflict", 64'(conflict), 64'd0);

    // Out-of-order row 5, then a clean frame with overlapping colours.
    add(1, oh(0), 8'h11, 8'h22, 0, 0, 0);
    add(1, oh(1), 8'h11, 8'h22, 0, 0, 0);
    add(1, oh(2), 8'h11, 8'h22, 0, 0, 0);
    add(1, oh(5), 8'h11, 8'h22, 0, 1, 0);
    add(1, oh(6), 8'h11, 8'h22, 0, 0, 0);
    run_table();
    chk("seq.frame_r_kept", frame_r, 64'h00000000_183C7EFF);
    for (int k = 0; k < 8; k++) add(1, oh(k), 8'h0F, (k == 6) ? 8'h01 : 8'hF0, 0, 0, 0);
    add(0, 8'hFF, 0, 0, 1, 0, 0);
    run_table();
    chk("seq.red_count", 64'(red_count), 64'd32);
    chk("seq.green_count", 64'(green_count), 64'd29);
    chk("seq.conflict", 64'(conflict), 64'd1);

    // Bad row patterns, including row 0 restart mid-frame.
    add(1, oh(0), 8'h01, 8'h00, 0, 0, 0);
    add(1, oh(1), 8'h01, 8'h00, 0, 0, 0);
    add(1, 8'h00, 8'h01, 8'h00, 0, 0, 1);
    add(1, 8'hFC, 8'h01, 8'h00, 0, 0, 1);
    add(1, 8'hFF, 8'h01, 8'h00, 0, 0, 1);
    add(1, oh(3), 8'h01, 8'h00, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(1, oh(k), 8'h80, 8'h00, 0, 0, 0);
    add(1, oh(0), 8'h80, 8'h00, 1, 0, 0);
    add(1, oh(1), 8'h80, 8'h00, 0, 0, 0);
    add(1, oh(0), 8'h80, 8'h00, 0, 1, 0);
    run_table();
    chk("bad.frame_r", frame_r, 64'h80808080_80808080);
    chk("bad.red_count", 64'(red_count), 64'd8);

    // Stall mid-frame: resume at row 4 ignored, resume at row 0 works.
    for (int k = 1; k < 4; k++) step(1, oh(k), 8'h42, 8'h24);
    for (int i = 0; i < T - 1; i++) step(0, 8'hFF, 0, 0);
    chk("stall.before", 64'(stall), 64'd0);
    step(0, 8'hFF, 0, 0);
    chk("stall.reached", 64'(stall), 64'd1);
    step(1, oh(4), 8'h42, 8'h24);
    chk("stall.row4_seq", 64'(seq_err), 64'd0);
    chk("stall.cleared", 64'(stall), 64'd0);
    for (int k = 5; k < 8; k++) step(1, oh(k), 8'h42, 8'h24);
    step(0, 8'hFF, 0, 0);
    chk("stall.no_frame", 64'(frame_valid), 64'd0);
    for (int k = 0; k < 8; k++) step(1, oh(k), 8'h42, 8'h24);
    step(0, 8'hFF, 0, 0);
    chk("stall.resume_fv", 64'(frame_valid), 64'd1);
    chk("stall.resume_r", frame_r, 64'h42424242_42424242);

    // Change detection after a fresh reset.
    do_reset();
    chk("reset.frame_r", frame_r, 64'd0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) step(1, oh(k), 8'h24, (f == 2 && k == 3) ? 8'h08 : 8'h18);
      step(0, 8'hFF, 0, 0);
      chk($sformatf("chg.fv%0d", f), 64'(frame_valid), 64'd1);
      chk($sformatf("chg.fc%0d", f), 64'(frame_changed), 64'(CHG_EN && f != 1));
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      int nxt;
      logic [7:0] rw;
      sel = $urandom_range(0, 99);
      nxt = synced ? run.size() : 0;
      if (sel < 1) begin
        for (int i = 0; i < T + 2; i++) step(0, 8'hFF, 0, 0);
      end else if (sel < 15) begin
        step(0, 8'(8'($urandom)), 8'($urandom), 8'($urandom));
      end else begin
        if (sel < 80) rw = oh(nxt);
        else if (sel < 90) rw = oh($urandom_range(0, 7));
        else begin
          rw = 8'($urandom);
          if ($countones(~rw) == 1) rw = rw & 8'hF0;
        end
        step(1, rw, 8'($urandom), 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_scan_capture.md
Name: led_scan_capture

Overview:
- Receive-side counterpart of the 8x8 bicolour row-scan matrix driver.
- Samples the multiplexed row, red-column and green-column scan outputs and rebuilds a full 64-pixel red/green frame.
- Checks scan-sequence integrity and reports per-frame lit-pixel counts, for self-test and on-board display readback.

Parameters:
- TIMEOUT, 1023, number of clk cycles without an accepted row sample before the stall flag asserts (1..65535).

Ports:
- clk  in  1  system clock, same clock as the scan driver's row-scan clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  when high, row/r_col/g_col are valid and are sampled this cycle.
- row  in  8  active-low one-hot row select; bit k low selects row k.
- r_col  in  8  red column data, 1 = lit.
- g_col  in  8  green column data, 1 = lit.
- frame_r  out  64  last complete red frame; bit (8*k + c) = r_col[c] captured on row k.
- frame_g  out  64  last complete green frame, same mapping as frame_r.
- frame_valid  out  1  one-cycle pulse when frame_r/frame_g/counts update.
- red_count  out  7  lit red pixels in last frame (0..64).
- green_count  out  7  lit green pixels in last frame (0..64).
- conflict  out  1  last frame had at least one pixel lit in both colours.
- seq_err  out  1  one-cycle pulse on an out-of-order row.
- bad_row  out  1  one-cycle pulse when row is not exactly one zero bit.
- stall  out  1  level; high while the timeout counter has reached TIMEOUT.
- frame_changed  out  1  see Optional Feature.

Behaviour:
- Reset (async, rst=1): all outputs 0, shadow buffers 0, accumulators 0, state SYNC, expected row 0, timeout counter 0.
- The shadow buffers (shadow_r, shadow_g) are written during capture; frame_r/frame_g change only on publish.
- Sample acceptance happens on a clk edge with sample_en=1. With sample_en=0: no state change except the timeout count.
- Row decode: exactly one 0 bit in row gives index k. Any other pattern (0xFF, two or more zeros) gives bad_row pulse next cycle, state SYNC, accumulators cleared. bad_row takes precedence over seq_err.
- State SYNC: wait for k=0. On k=0, capture row 0 into shadow, set accumulators to popcount(r_col)/popcount(g_col), expected=1, go to CAPTURE. Any other valid k is ignored silently (no seq_err).
- State CAPTURE:
  - If k == expected: write shadow row k, add popcounts, OR (r_col & g_col) into the conflict accumulator.
  - If k == 7: publish. On the next edge frame_r/frame_g/red_count/green_count/conflict load from shadow+accumulators and frame_valid pulses for one cycle. State stays CAPTURE with expected=0, so back-to-back frames need no resync. Row 0 may arrive in the cycle right after row 7; the pulse and the new capture do not interfere.
  - Otherwise expected = k+1.
  - If k != expected: seq_err pulses one cycle, partial frame discarded. If k==0 the row-0 capture restarts immediately (stay CAPTURE, expected=1); else go to SYNC.
- Latency: row 7 sampled at edge N, then outputs and frame_valid are visible after edge N+1.
- Counts: accumulators are 7 bits, max 64, no wrap possible. Popcount of 8 bits is 0..8.
- Timeout:
  - The counter clears on every accepted sample (any valid or invalid row with sample_en=1) and otherwise increments, saturating at TIMEOUT.
  - stall = (counter == TIMEOUT).
  - Reaching TIMEOUT also forces state SYNC.
  - stall drops the cycle after the next accepted sample.
- Published frame outputs persist through errors and stalls; only rst clears them.

Optional Feature:
- Macro LED_SCAN_CAPTURE_CHANGE_EN.
- Defined: on each publish, compare the new frame_r/frame_g against the previous published frame. frame_changed pulses high in the same cycle as frame_valid if they differ. The first frame after reset is compared against the all-zero reset frame.
- Undefined: frame_changed is tied to 0 and no comparison logic is built.

Test Plan:
- Reset, then rows 0..7 in order with sample_en=1, r_col=0xFF, g_col=0x00 -> frame_valid pulse 1 cycle after row 7; frame_r=all ones, frame_g=0, red_count=64, green_count=0, conflict=0.
- Hourglass pattern: row0 r=0xFF, row1 r=0x7E, row2 r=0x3C, row3 r=0x18, rows4-7 g = those values mirrored, all other column bits 0 -> red_count=20, green_count=20, conflict=0, bit mapping matches 8*k+c.
- Rows 0,1,2,5 -> seq_err pulse on 5, no frame_valid, state SYNC. Then a full 0..7 sequence -> valid frame published; earlier outputs unchanged until then.
- Row 0x00 mid-frame -> bad_row pulse, no seq_err. Row 0xFC -> bad_row. A following clean frame publishes normally.
- sample_en=0 for TIMEOUT cycles mid-frame -> stall=1, state SYNC. A resume at row 4 is ignored; a resume at row 0 yields a frame after 8 samples, and stall clears.
- With LED_SCAN_CAPTURE_CHANGE_EN: two identical frames, then one with row3 g_col 0x18->0x08 -> frame_changed pulses with the 1st and 3rd frame_valid only. Without the macro: frame_changed stays 0.
